// File: rtl/cpu_trace_emitter.sv
// cpu_trace_emitter: turns one retired-write record into its canonical ASCII
// trace line, streamed one character per accepted valid/ready transfer.
module cpu_trace_emitter #(
  parameter int TIME_W = 14,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_kind,
  input  logic [TIME_W-1:0] in_time,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_data,
  output logic [7:0]        char,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              frame_done,
  output logic              time_clamped
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        kind_q, kind_d;
  logic [15:0] tdig_q, tdig_d;
  logic [2:0]  tlen_q, tlen_d;
  logic [7:0]  rdig_q, rdig_d;
  logic [1:0]  rlen_q, rlen_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, data_q, data_d;
  logic [5:0]  pos_q, pos_d;
  logic [7:0]  char_q, char_d;
  logic        char_valid_q, char_valid_d, in_ready_q, in_ready_d;
  logic        frame_done_q, frame_done_d, time_clamped_q, time_clamped_d;

  logic [31:0] time_ext_s;
  logic        clamp_s;
  logic [13:0] time_s;
  logic [3:0]  d3_s, d2_s, d1_s, d0_s, r1_s, r0_s;
  logic [7:0]  reg_s;
  logic [5:0]  tl_s, fl_s, nxt_pos_s, last_pos_s;
  logic [1:0]  tk_s;
  logic        rk_s;
  logic [2:0]  pk_s, ak_s, dk_s;
  logic [7:0]  nxt_char_s;

  function automatic logic [7:0] hex_char(input logic [31:0] v, input logic [2:0] k);
    logic [31:0] sh;
    sh = v << {k, 2'b00};
    if (sh[31:28] < 4'd10) return {4'h3, sh[31:28]};
    else return 8'h57 + {4'h0, sh[31:28]};
  endfunction

  function automatic logic [7:0] dec_char(input logic [15:0] v, input logic [1:0] k);
    logic [15:0] sh;
    sh = v << {k, 2'b00};
    return {4'h3, sh[15:12]};
  endfunction

  // Decimal digits are converted at capture so the first '^' is never delayed.
  always_comb begin
    time_ext_s = 32'(in_time);
    clamp_s    = (time_ext_s > 32'd9999);
    time_s     = clamp_s ? 14'd9999 : time_ext_s[13:0];
    d3_s       = 4'(time_s / 14'd1000);
    d2_s       = 4'((time_s / 14'd100) % 14'd10);
    d1_s       = 4'((time_s / 14'd10) % 14'd10);
    d0_s       = 4'(time_s % 14'd10);
    reg_s      = 8'(in_addr[REG_W-1:0]);
    r1_s       = 4'(reg_s / 8'd10);
    r0_s       = 4'(reg_s % 8'd10);
  end

  // Character at the next frame position; fields shift right by the time length.
  always_comb begin
    tl_s       = {3'd0, tlen_q};
    fl_s       = kind_q ? 6'd8 : {4'd0, rlen_q};
    nxt_pos_s  = pos_q + 6'd1;
    last_pos_s = tl_s + fl_s + 6'd25;
    tk_s       = 2'(nxt_pos_s + 6'd3 - tl_s);
    rk_s       = 1'(nxt_pos_s - tl_s - 6'd11 - {4'd0, rlen_q});
    pk_s       = 3'(nxt_pos_s - tl_s - 6'd2);
    ak_s       = 3'(nxt_pos_s - tl_s - 6'd13);
    dk_s       = 3'(nxt_pos_s - tl_s - fl_s - 6'd17);
    nxt_char_s = 8'h23;
    if (nxt_pos_s <= tl_s) nxt_char_s = dec_char(tdig_q, tk_s);
    else if (nxt_pos_s == tl_s + 6'd1) nxt_char_s = 8'h40;
    else if (nxt_pos_s <= tl_s + 6'd9) nxt_char_s = hex_char(pc_q, pk_s);
    else if (nxt_pos_s == tl_s + 6'd10) nxt_char_s = 8'h3a;
    else if (nxt_pos_s == tl_s + 6'd11) nxt_char_s = 8'h20;
    else if (nxt_pos_s == tl_s + 6'd12) nxt_char_s = kind_q ? 8'h2a : 8'h24;
    else if (nxt_pos_s <= tl_s + 6'd12 + fl_s)
      nxt_char_s = kind_q ? hex_char(addr_q, ak_s) : dec_char({rdig_q, 8'h00}, {1'b0, rk_s});
    else if (nxt_pos_s == tl_s + fl_s + 6'd13) nxt_char_s = 8'h20;
    else if (nxt_pos_s == tl_s + fl_s + 6'd14) nxt_char_s = 8'h3c;
    else if (nxt_pos_s == tl_s + fl_s + 6'd15) nxt_char_s = 8'h3d;
    else if (nxt_pos_s == tl_s + fl_s + 6'd16) nxt_char_s = 8'h20;
    else if (nxt_pos_s <= tl_s + fl_s + 6'd24) nxt_char_s = hex_char(data_q, dk_s);
    else nxt_char_s = 8'h23;
  end

  always_comb begin
    state_d = state_q;   kind_d = kind_q;   tdig_d = tdig_q;   tlen_d = tlen_q;
    rdig_d = rdig_q;     rlen_d = rlen_q;   pc_d = pc_q;       addr_d = addr_q;
    data_d = data_q;     pos_d = pos_q;     char_d = char_q;
    char_valid_d = char_valid_q;  in_ready_d = in_ready_q;
    frame_done_d = 1'b0;          time_clamped_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d        = SEND;
          in_ready_d     = 1'b0;
          char_valid_d   = 1'b1;
          char_d         = 8'h5e;
          pos_d          = 6'd0;
          kind_d         = in_kind;
          tdig_d         = {d3_s, d2_s, d1_s, d0_s};
          tlen_d         = (time_s >= 14'd1000) ? 3'd4 : (time_s >= 14'd100) ? 3'd3 :
                           (time_s >= 14'd10) ? 3'd2 : 3'd1;
          rdig_d         = {r1_s, r0_s};
          rlen_d         = (reg_s >= 8'd10) ? 2'd2 : 2'd1;
          pc_d           = in_pc;
          addr_d         = in_addr;
          data_d         = in_data;
          time_clamped_d = clamp_s;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      SEND: begin
        if (char_ready && pos_q == last_pos_s) begin
          state_d      = IDLE;
          char_valid_d = 1'b0;
          char_d       = 8'h00;
          in_ready_d   = 1'b1;
          frame_done_d = 1'b1;
        end else if (char_ready) begin
          pos_d  = nxt_pos_s;
          char_d = nxt_char_s;
        end else begin
          pos_d = pos_q;
        end
      end
      default: begin
        state_d      = IDLE;
        char_valid_d = 1'b0;
        char_d       = 8'h00;
        in_ready_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;   kind_q <= 1'b0;    tdig_q <= 16'h0000; tlen_q <= 3'd1;
      rdig_q <= 8'h00;   rlen_q <= 2'd1;    pc_q <= 32'h0;      addr_q <= 32'h0;
      data_q <= 32'h0;   pos_q <= 6'd0;     char_q <= 8'h00;
      char_valid_q <= 1'b0;  in_ready_q <= 1'b1;
      frame_done_q <= 1'b0;  time_clamped_q <= 1'b0;
    end else begin
      state_q <= state_d;  kind_q <= kind_d;  tdig_q <= tdig_d;  tlen_q <= tlen_d;
      rdig_q <= rdig_d;    rlen_q <= rlen_d;  pc_q <= pc_d;      addr_q <= addr_d;
      data_q <= data_d;    pos_q <= pos_d;    char_q <= char_d;
      char_valid_q <= char_valid_d;  in_ready_q <= in_ready_d;
      frame_done_q <= frame_done_d;  time_clamped_q <= time_clamped_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign char         = char_q;
  assign char_valid   = char_valid_q;
  assign frame_done   = frame_done_q;
  assign time_clamped = time_clamped_q;

endmodule
